hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/forward_sel.sv | 26 ++
 rtl/hazard_unit.sv | 138 +++++++++++++
 tb/tb_hazard_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard unit: controller states,
// operand forward selects and execute-stage writeback selects.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_FLUSH = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_IMM  = 2'b11;

endpackage

// File: rtl/forward_sel.sv
// Forward-select for one execute-stage operand; the memory-stage producer
// is younger than the writeback one, so it wins when both match.
module forward_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] raddr,
    input  logic [REG_AW-1:0] waddr_m,
    input  logic              reg_wr_m,
    input  logic [REG_AW-1:0] waddr_w,
    input  logic              reg_wr_w,
    output logic [1:0]        fwd
);

    // x0 is hard-wired to zero, so it never sources a forward.
    always_comb begin
        fwd = FWD_RF;
        if (reg_wr_m && (waddr_m != '0) && (waddr_m == raddr)) begin
            fwd = FWD_MEM;
        end else if (reg_wr_w && (waddr_w != '0) && (waddr_w == raddr)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch redirect
// flush and data-memory wait. Define HAZARD_PERF_CNT_EN to add stall/flush counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] raddr1D,
    input  logic [REG_AW-1:0] raddr2D,
    input  logic [REG_AW-1:0] raddr1E,
    input  logic [REG_AW-1:0] raddr2E,
    input  logic [REG_AW-1:0] waddrE,
    input  logic [REG_AW-1:0] waddrM,
    input  logic [REG_AW-1:0] waddrW,
    input  logic              reg_wrE,
    input  logic              reg_wrM,
    input  logic              reg_wrW,
    input  logic [1:0]        wb_selE,
    input  logic              br_taken,
    input  logic              mem_busy,
    output logic [1:0]        For_A,
    output logic [1:0]        For_B,
    output logic              Stall,
    output logic              FlushD,
    output logic              FlushE
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    hazard_state_e state;
    hazard_state_e next_state;
    logic          pending;
    logic          pending_next;
    logic          load_use;

    forward_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .raddr    (raddr1E),
        .waddr_m  (waddrM),
        .reg_wr_m (reg_wrM),
        .waddr_w  (waddrW),
        .reg_wr_w (reg_wrW),
        .fwd      (For_A)
    );

    forward_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .raddr    (raddr2E),
        .waddr_m  (waddrM),
        .reg_wr_m (reg_wrM),
        .waddr_w  (waddrW),
        .reg_wr_w (reg_wrW),
        .fwd      (For_B)
    );

    assign load_use = (wb_selE == WB_LOAD) && reg_wrE && (waddrE != '0) &&
                      ((waddrE == raddr1D) || (waddrE == raddr2D));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            pending <= 1'b0;
        end else begin
            state   <= next_state;
            pending <= pending_next;
        end
    end

    // pending remembers a second-cycle branch flush swallowed by a memory wait.
    always_comb begin
        next_state   = state;
        pending_next = 1'b0;
        if (mem_busy) begin
            next_state   = MEM_WAIT;
            pending_next = pending || (state == BR_FLUSH);
        end else begin
            case (state)
                RUN, MEM_WAIT: next_state = br_taken ? BR_FLUSH : RUN;
                BR_FLUSH:      next_state = RUN;
                default:       next_state = RUN;
            endcase
        end
    end

    // Leaving MEM_WAIT behaves like RUN, except an owed flush goes out first
    // unless a fresh branch already flushes both stages.
    always_comb begin
        Stall  = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (rst) begin
            if (mem_busy) begin
                Stall = 1'b1;
            end else begin
                case (state)
                    RUN, MEM_WAIT: begin
                        if (br_taken) begin
                            FlushD = 1'b1;
                            FlushE = 1'b1;
                        end else if ((state == MEM_WAIT) && pending) begin
                            FlushD = 1'b1;
                        end else if (load_use) begin
                            Stall  = 1'b1;
                            FlushE = 1'b1;
                        end
                    end
                    BR_FLUSH: FlushD = 1'b1;
                    default: begin
                        Stall  = 1'b0;
                        FlushD = 1'b0;
                        FlushE = 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (Stall) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (FlushD || FlushE) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_hazard_unit;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;

    typedef struct packed {
        logic              rst;
        logic [REG_AW-1:0] raddr1D;
        logic [REG_AW-1:0] raddr2D;
        logic [REG_AW-1:0] raddr1E;
        logic [REG_AW-1:0] raddr2E;
        logic [REG_AW-1:0] waddrE;
        logic [REG_AW-1:0] waddrM;
        logic [REG_AW-1:0] waddrW;
        logic              reg_wrE;
        logic              reg_wrM;
        logic              reg_wrW;
        logic [1:0]        wb_selE;
        logic              br_taken;
        logic              mem_busy;
    } stim_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [REG_AW-1:0] raddr1D = '0, raddr2D = '0, raddr1E = '0, raddr2E = '0;
    logic [REG_AW-1:0] waddrE = '0, waddrM = '0, waddrW = '0;
    logic              reg_wrE = 1'b0, reg_wrM = 1'b0, reg_wrW = 1'b0;
    logic [1:0]        wb_selE = 2'b00;
    logic              br_taken = 1'b0, mem_busy = 1'b0;
    logic [1:0]        For_A, For_B;
    logic              Stall, FlushD, FlushE;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: branch flush cycles still owed, and whether the previous
    // cycle was spent waiting on memory.
    int               m_owed = 0;
    bit               m_after_wait = 1'b0;
    logic [CNT_W-1:0] m_stall_cnt = '0;
    logic [CNT_W-1:0] m_flush_cnt = '0;

    hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .raddr1D  (raddr1D),
        .raddr2D  (raddr2D),
        .raddr1E  (raddr1E),
        .raddr2E  (raddr2E),
        .waddrE   (waddrE),
        .waddrM   (waddrM),
        .waddrW   (waddrW),
        .reg_wrE  (reg_wrE),
        .reg_wrM  (reg_wrM),
        .reg_wrW  (reg_wrW),
        .wb_selE  (wb_selE),
        .br_taken (br_taken),
        .mem_busy (mem_busy),
        .For_A    (For_A),
        .For_B    (For_B),
        .Stall    (Stall),
        .FlushD   (FlushD),
`ifdef HAZARD_PERF_CNT_EN
        .FlushE   (FlushE),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`else
        .FlushE   (FlushE)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [1:0] refFwd(input logic [REG_AW-1:0] ra, input stim_t s);
        if (ra != 0 && s.reg_wrM && s.waddrM == ra) return 2'b01;
        if (ra != 0 && s.reg_wrW && s.waddrW == ra) return 2'b10;
        return 2'b00;
    endfunction

    // One clock cycle: drive just after the rising edge, check mid-cycle,
    // then advance the model to what the next edge should produce.
    task automatic applyStimulus(input stim_t s, input string tag);
        logic exp_stall, exp_fd, exp_fe;
        bit   lu;
        @(posedge clk);
        #1;
        rst      = s.rst;
        raddr1D  = s.raddr1D;
        raddr2D  = s.raddr2D;
        raddr1E  = s.raddr1E;
        raddr2E  = s.raddr2E;
        waddrE   = s.waddrE;
        waddrM   = s.waddrM;
        waddrW   = s.waddrW;
        reg_wrE  = s.reg_wrE;
        reg_wrM  = s.reg_wrM;
        reg_wrW  = s.reg_wrW;
        wb_selE  = s.wb_selE;
        br_taken = s.br_taken;
        mem_busy = s.mem_busy;
        #4;
        lu = (s.wb_selE == 2'b01) && s.reg_wrE && (s.waddrE != 0) &&
             ((s.waddrE == s.raddr1D) || (s.waddrE == s.raddr2D));
        exp_stall = 1'b0;
        exp_fd    = 1'b0;
        exp_fe    = 1'b0;
        if (!s.rst) begin
            m_owed       = 0;
            m_after_wait = 1'b0;
            m_stall_cnt  = '0;
            m_flush_cnt  = '0;
        end else if (s.mem_busy) begin
            exp_stall    = 1'b1;
            m_after_wait = 1'b1;
        end else begin
            if (m_owed > 0 && !m_after_wait) begin
                exp_fd = 1'b1;
                m_owed = 0;
            end else if (s.br_taken) begin
                exp_fd = 1'b1;
                exp_fe = 1'b1;
                m_owed = 1;
            end else if (m_owed > 0) begin
                exp_fd = 1'b1;
                m_owed = 0;
            end else if (lu) begin
                exp_stall = 1'b1;
                exp_fe    = 1'b1;
            end
            m_after_wait = 1'b0;
        end
        checkOutput({tag, ".For_A"},  32'(For_A),  32'(refFwd(s.raddr1E, s)));
        checkOutput({tag, ".For_B"},  32'(For_B),  32'(refFwd(s.raddr2E, s)));
        checkOutput({tag, ".Stall"},  32'(Stall),  32'(exp_stall));
        checkOutput({tag, ".FlushD"}, 32'(FlushD), 32'(exp_fd));
        checkOutput({tag, ".FlushE"}, 32'(FlushE), 32'(exp_fe));
`ifdef HAZARD_PERF_CNT_EN
        checkOutput({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall_cnt));
        checkOutput({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush_cnt));
`endif
        if (s.rst) begin
            m_stall_cnt = m_stall_cnt + CNT_W'(exp_stall);
            m_flush_cnt = m_flush_cnt + CNT_W'(exp_fd | exp_fe);
        end
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s     = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic stim_t loadUseStim(input logic [REG_AW-1:0] rd);
        stim_t s;
        s         = idleStim();
        s.wb_selE = 2'b01;
        s.reg_wrE = 1'b1;
        s.waddrE  = rd;
        s.raddr2D = rd;
        return s;
    endfunction

    initial begin
        stim_t s;

        // Reset with hazards present: control must stay quiet, forwarding live.
        s          = loadUseStim(5'd3);
        s.rst      = 1'b0;
        s.br_taken = 1'b1;
        s.raddr1E  = 5'd4;
        s.waddrW   = 5'd4;
        s.reg_wrW  = 1'b1;
        applyStimulus(s, "reset0");
        applyStimulus(s, "reset1");
        checkOutput("reset_fwd_wb", 32'(For_A), 32'h2);

        // Memory stage beats writeback stage.
        s         = idleStim();
        s.raddr1E = 5'd5;
        s.waddrM  = 5'd5;
        s.reg_wrM = 1'b1;
        s.waddrW  = 5'd5;
        s.reg_wrW = 1'b1;
        applyStimulus(s, "mem_prio");
        checkOutput("mem_prio_const", 32'(For_A), 32'h1);

        // Load-use on x7: one stall cycle, then clear.
        applyStimulus(loadUseStim(5'd7), "load_use");
        checkOutput("load_use_stall", 32'(Stall), 32'h1);
        applyStimulus(idleStim(), "load_use_after");
        checkOutput("load_use_clear", 32'(Stall), 32'h0);

        // Branch overrides a concurrent load-use; two-cycle redirect.
        s          = loadUseStim(5'd9);
        s.br_taken = 1'b1;
        applyStimulus(s, "br_lu_n0");
        checkOutput("br_lu_nostall", 32'(Stall), 32'h0);
        applyStimulus(idleStim(), "br_lu_n1");
        checkOutput("br_lu_n1_fd", 32'(FlushD), 32'h1);
        applyStimulus(idleStim(), "br_lu_n2");
        checkOutput("br_lu_n2_fd", 32'(FlushD), 32'h0);

        // Branch, then three memory-wait cycles delay the second flush.
        s          = idleStim();
        s.br_taken = 1'b1;
        applyStimulus(s, "br_wait_n0");
        s          = idleStim();
        s.mem_busy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(s, $sformatf("br_wait_n%0d", i));
        end
        applyStimulus(idleStim(), "br_wait_n4");
        checkOutput("br_wait_late_fd", 32'(FlushD), 32'h1);
        applyStimulus(idleStim(), "br_wait_n5");

        // x0 neither forwards nor stalls.
        s         = loadUseStim(5'd0);
        s.waddrM  = 5'd0;
        s.reg_wrM = 1'b1;
        applyStimulus(s, "x0");
        checkOutput("x0_fwd", 32'(For_A), 32'h0);

        // Reset in the middle of a redirect abandons it.
        s          = idleStim();
        s.br_taken = 1'b1;
        applyStimulus(s, "rst_mid_n0");
        s          = idleStim();
        s.rst      = 1'b0;
        applyStimulus(s, "rst_mid_n1");
        checkOutput("rst_mid_fd", 32'(FlushD), 32'h0);
        applyStimulus(idleStim(), "rst_mid_n2");
        applyStimulus(idleStim(), "rst_mid_n3");

        // Randomized traffic over a narrow register range to force collisions.
        for (int i = 0; i < 600; i++) begin
            s.rst      = ($urandom_range(0, 99) >= 2);
            s.raddr1D  = REG_AW'($urandom_range(0, 7));
            s.raddr2D  = REG_AW'($urandom_range(0, 7));
            s.raddr1E  = REG_AW'($urandom_range(0, 7));
            s.raddr2E  = REG_AW'($urandom_range(0, 7));
            s.waddrE   = REG_AW'($urandom_range(0, 7));
            s.waddrM   = REG_AW'($urandom_range(0, 7));
            s.waddrW   = REG_AW'($urandom_range(0, 7));
            s.reg_wrE  = 1'($urandom_range(0, 1));
            s.reg_wrM  = 1'($urandom_range(0, 1));
            s.reg_wrW  = 1'($urandom_range(0, 1));
            s.wb_selE  = 2'($urandom_range(0, 3));
            s.br_taken = ($urandom_range(0, 99) < 20);
            s.mem_busy = ($urandom_range(0, 99) < 15);
            applyStimulus(s, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
